icache_waysel_stage: RTL and testbench

ICACHE_WAYSEL_STAGE -- requirements
Module: icache_waysel_stage

---
 rtl/icache_waysel_stage.sv | 108 ++++++++++
 tb/tb_icache_waysel_stage.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_waysel_stage.sv
// I-cache s0->s1 way-select stage: registers the tag lookup, decodes hit/multi-hit,
// and runs a small miss-request FSM that stalls the stage until the fill returns.
module icache_waysel_stage #(
   parameter int MHIT_CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  s0_vld,
   input  logic [3:0]            s0_tag_match,
   input  logic [3:0]            s0_way_vld,
   input  logic [3:0]            s0_tag_perr,
   input  logic                  s0_tlb_cam_miss,
   input  logic                  s0_cam_vld,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  fill_ack,
   output logic [3:0]            waysel_buf_s1,
   output logic [3:0]            alltag_err_s1,
   output logic                  tlb_cam_miss_s1,
   output logic                  cam_vld_s1,
   output logic                  hit_s1,
   output logic [1:0]            hit_way_s1,
   output logic                  mhit_s1,
   output logic                  miss_req,
   output logic                  busy,
   output logic [MHIT_CNT_W-1:0] mhit_cnt
);

   // state | meaning
   // IDLE  | no miss outstanding, s1 advances freely
   // REQ   | miss request presented for one cycle
   // WAIT  | waiting for fill_ack
   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t state, state_nxt;

   logic       advance;
   logic       clean;
   logic [3:0] s0_waysel;
   logic       s0_mhit;

   assign advance   = ~stall & ~busy;
   assign clean     = cam_vld_s1 & ~|alltag_err_s1 & ~tlb_cam_miss_s1;
   assign s0_waysel = s0_tag_match & s0_way_vld;
   // Multi-hit on the incoming entry, evaluated with the same terms as mhit_s1.
   assign s0_mhit   = s0_vld & s0_cam_vld & ~|s0_tag_perr & ~s0_tlb_cam_miss
                      & ((s0_waysel & (s0_waysel - 4'd1)) != 4'd0);

   assign hit_s1  = clean & |waysel_buf_s1;
   assign mhit_s1 = clean & ((waysel_buf_s1 & (waysel_buf_s1 - 4'd1)) != 4'd0);

   always_comb begin
      hit_way_s1 = 2'd0;
      casez (waysel_buf_s1)
         4'b???1: hit_way_s1 = 2'd0;
         4'b??10: hit_way_s1 = 2'd1;
         4'b?100: hit_way_s1 = 2'd2;
         4'b1000: hit_way_s1 = 2'd3;
         default: hit_way_s1 = 2'd0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      miss_req  = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (clean && waysel_buf_s1 == 4'd0 && !flush) state_nxt = REQ;
         end
         REQ: begin
            miss_req  = 1'b1;
            state_nxt = flush ? IDLE : WAIT;
         end
         WAIT: begin
            if (fill_ack) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         waysel_buf_s1   <= 4'd0;
         alltag_err_s1   <= 4'd0;
         tlb_cam_miss_s1 <= 1'b0;
         cam_vld_s1      <= 1'b0;
         mhit_cnt        <= '0;
      end else begin
         state <= state_nxt;
         if (advance) begin
            waysel_buf_s1   <= s0_waysel;
            alltag_err_s1   <= s0_tag_perr;
            tlb_cam_miss_s1 <= s0_tlb_cam_miss;
         end
         // The entry behind a completed fill is replayed upstream, so it is dropped here.
         if (flush || (state == WAIT && fill_ack))
            cam_vld_s1 <= 1'b0;
         else if (advance)
            cam_vld_s1 <= s0_vld & s0_cam_vld;
         if (advance && s0_mhit && mhit_cnt != {MHIT_CNT_W{1'b1}})
            mhit_cnt <= mhit_cnt + MHIT_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_icache_waysel_stage.sv
// Self-checking bench for icache_waysel_stage: directed scenarios plus random
// traffic compared against a behavioural model of the stage.
module tb_icache_waysel_stage;

   localparam int W = 8;
   localparam int M_IDLE = 0, M_REQ = 1, M_WAIT = 2;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         s0_vld = 1'b0;
   logic [3:0]   s0_tag_match = 4'd0;
   logic [3:0]   s0_way_vld = 4'd0;
   logic [3:0]   s0_tag_perr = 4'd0;
   logic         s0_tlb_cam_miss = 1'b0;
   logic         s0_cam_vld = 1'b0;
   logic         stall = 1'b0;
   logic         flush = 1'b0;
   logic         fill_ack = 1'b0;
   logic [3:0]   waysel_buf_s1, alltag_err_s1;
   logic         tlb_cam_miss_s1, cam_vld_s1, hit_s1, mhit_s1, miss_req, busy;
   logic [1:0]   hit_way_s1;
   logic [W-1:0] mhit_cnt;

   int checks = 0;
   int failures = 0;

   // Behavioural model of the s1 entry and the miss handshake
   logic [3:0]   m_way, m_err;
   logic         m_tlb, m_cam;
   int           m_state;
   int           m_cnt;

   icache_waysel_stage #(.MHIT_CNT_W(W)) dut (
      .clk(clk), .reset(reset), .s0_vld(s0_vld), .s0_tag_match(s0_tag_match),
      .s0_way_vld(s0_way_vld), .s0_tag_perr(s0_tag_perr),
      .s0_tlb_cam_miss(s0_tlb_cam_miss), .s0_cam_vld(s0_cam_vld),
      .stall(stall), .flush(flush), .fill_ack(fill_ack),
      .waysel_buf_s1(waysel_buf_s1), .alltag_err_s1(alltag_err_s1),
      .tlb_cam_miss_s1(tlb_cam_miss_s1), .cam_vld_s1(cam_vld_s1),
      .hit_s1(hit_s1), .hit_way_s1(hit_way_s1), .mhit_s1(mhit_s1),
      .miss_req(miss_req), .busy(busy), .mhit_cnt(mhit_cnt)
   );

   always #5 clk = ~clk;

   logic [23:0] dut_vec;
   assign dut_vec = {waysel_buf_s1, alltag_err_s1, tlb_cam_miss_s1, cam_vld_s1,
                     hit_s1, hit_way_s1, mhit_s1, miss_req, busy, mhit_cnt};

   function automatic bit m_clean();
      return m_cam && m_err == 4'd0 && !m_tlb;
   endfunction

   function automatic logic [23:0] exp_vec();
      int lo;
      bit hit, mh;
      lo = 0;
      for (int i = 3; i >= 0; i--) if (m_way[i]) lo = i;
      hit = m_clean() && m_way != 4'd0;
      mh  = m_clean() && $countones(m_way) >= 2;
      return {m_way, m_err, m_tlb, m_cam, hit, 2'(lo), mh,
              m_state == M_REQ, m_state != M_IDLE, 8'(m_cnt)};
   endfunction

   // One clock: update the model from the inputs seen at the edge, then settle.
   task automatic step();
      bit adv, s0_mh;
      int nstate;
      logic [3:0] sel;
      @(posedge clk);
      sel   = s0_tag_match & s0_way_vld;
      adv   = !stall && m_state == M_IDLE;
      s0_mh = s0_vld && s0_cam_vld && s0_tag_perr == 4'd0 && !s0_tlb_cam_miss
              && $countones(sel) >= 2;
      if (reset) begin
         m_way = 0; m_err = 0; m_tlb = 0; m_cam = 0; m_state = M_IDLE; m_cnt = 0;
      end else begin
         nstate = m_state;
         if (m_state == M_IDLE && m_clean() && m_way == 4'd0 && !flush) nstate = M_REQ;
         else if (m_state == M_REQ) nstate = flush ? M_IDLE : M_WAIT;
         else if (m_state == M_WAIT && fill_ack) nstate = M_IDLE;
         if (flush || (m_state == M_WAIT && fill_ack)) m_cam = 0;
         else if (adv) m_cam = s0_vld && s0_cam_vld;
         if (adv) begin
            m_way = sel; m_err = s0_tag_perr; m_tlb = s0_tlb_cam_miss;
            if (s0_mh && m_cnt < 255) m_cnt++;
         end
         m_state = nstate;
      end
      #1;
   endtask

   task automatic idle_inputs();
      s0_vld = 0; s0_cam_vld = 0; s0_tag_match = 0; s0_way_vld = 0;
      s0_tag_perr = 0; s0_tlb_cam_miss = 0; stall = 0; flush = 0; fill_ack = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1;
      step();
      reset = 0;
   endtask

   task automatic load(input logic [3:0] match, input logic [3:0] perr, input logic tlb);
      s0_vld = 1; s0_cam_vld = 1; s0_tag_match = match; s0_way_vld = 4'hF;
      s0_tag_perr = perr; s0_tlb_cam_miss = tlb;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (dut_vec !== 24'd0) begin
         failures++; $display("FAIL reset_state got=%h exp=000000", dut_vec);
      end
   endtask

   task automatic test_hit();
      do_reset();
      load(4'b0100, 4'd0, 0);
      step();
      checks++;
      if ({hit_s1, hit_way_s1, mhit_s1} !== {1'b1, 2'd2, 1'b0}) begin
         failures++;
         $display("FAIL single_hit got hit=%b way=%0d mhit=%b exp hit=1 way=2 mhit=0",
                  hit_s1, hit_way_s1, mhit_s1);
      end
   endtask

   task automatic test_mhit_stall();
      do_reset();
      load(4'b0110, 4'd0, 0);
      step();
      checks++;
      if ({mhit_s1, hit_way_s1, mhit_cnt} !== {1'b1, 2'd1, 8'd1}) begin
         failures++;
         $display("FAIL multi_hit got mhit=%b way=%0d cnt=%0d exp mhit=1 way=1 cnt=1",
                  mhit_s1, hit_way_s1, mhit_cnt);
      end
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (mhit_cnt !== 8'd1 || mhit_s1 !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold cyc=%0d got cnt=%0d mhit=%b exp cnt=1 mhit=1",
                     i, mhit_cnt, mhit_s1);
         end
      end
      stall = 0;
   endtask

   task automatic test_miss();
      int req_cycles, busy_cycles;
      do_reset();
      load(4'b0000, 4'd0, 0);
      step();
      checks++;
      if (hit_s1 !== 1'b0 || miss_req !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL miss_s1 got hit=%b req=%b busy=%b exp 0 0 0",
                              hit_s1, miss_req, busy);
      end
      req_cycles = 0; busy_cycles = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (miss_req) req_cycles++;
         if (busy) busy_cycles++;
      end
      checks++;
      if (req_cycles != 1 || busy_cycles != 6) begin
         failures++; $display("FAIL miss_handshake got req_cycles=%0d busy_cycles=%0d exp 1 6",
                              req_cycles, busy_cycles);
      end
      fill_ack = 1; s0_vld = 0;
      step();
      fill_ack = 0;
      checks++;
      if (busy !== 1'b0 || cam_vld_s1 !== 1'b0 || miss_req !== 1'b0) begin
         failures++; $display("FAIL fill_done got busy=%b cam_vld=%b req=%b exp 0 0 0",
                              busy, cam_vld_s1, miss_req);
      end
   endtask

   task automatic test_err();
      for (int k = 0; k < 2; k++) begin
         do_reset();
         if (k == 0) load(4'b0000, 4'b0001, 0);
         else        load(4'b0110, 4'b0000, 1);
         for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (hit_s1 !== 1'b0 || mhit_s1 !== 1'b0 || miss_req !== 1'b0 || busy !== 1'b0) begin
               failures++;
               $display("FAIL err_entry k=%0d got hit=%b mhit=%b req=%b busy=%b exp 0 0 0 0",
                        k, hit_s1, mhit_s1, miss_req, busy);
            end
         end
      end
   endtask

   task automatic test_flush_req();
      do_reset();
      load(4'b0000, 4'd0, 0);
      step();
      s0_vld = 0;
      step();
      flush = 1;
      checks++;
      if (miss_req !== 1'b1) begin
         failures++; $display("FAIL req_state got req=%b exp 1", miss_req);
      end
      step();
      flush = 0;
      checks++;
      if (busy !== 1'b0 || miss_req !== 1'b0 || cam_vld_s1 !== 1'b0) begin
         failures++; $display("FAIL flush_in_req got busy=%b req=%b cam_vld=%b exp 0 0 0",
                              busy, miss_req, cam_vld_s1);
      end
   endtask

   task automatic test_reset_wait();
      do_reset();
      load(4'b0000, 4'd0, 0);
      step(); step(); step();
      checks++;
      if (busy !== 1'b1 || miss_req !== 1'b0) begin
         failures++; $display("FAIL wait_state got busy=%b req=%b exp 1 0", busy, miss_req);
      end
      reset = 1; stall = 1; flush = 1; fill_ack = 1;
      step();
      checks++;
      if (dut_vec !== 24'd0) begin
         failures++; $display("FAIL reset_in_wait got=%h exp=000000", dut_vec);
      end
      reset = 0;
      idle_inputs();
      step();
      checks++;
      if (busy !== 1'b0) begin
         failures++; $display("FAIL miss_abandoned got busy=%b exp 0", busy);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      load(4'b1011, 4'd0, 0);
      for (int i = 1; i <= 258; i++) begin
         step();
         if (i == 100 || i == 255 || i == 258) begin
            checks++;
            if (mhit_cnt !== 8'((i > 255) ? 255 : i)) begin
               failures++; $display("FAIL mhit_sat n=%0d got=%0d exp=%0d",
                                    i, mhit_cnt, (i > 255) ? 255 : i);
            end
         end
      end
      flush = 1;
      step();
      flush = 0;
      checks++;
      if (mhit_cnt !== 8'hFF) begin
         failures++; $display("FAIL mhit_sat_flush got=%0d exp=255", mhit_cnt);
      end
   endtask

   task automatic test_random();
      logic [23:0] e;
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         reset           = ($urandom_range(0, 99) == 0);
         s0_vld          = ($urandom_range(0, 7) != 0);
         s0_cam_vld      = ($urandom_range(0, 7) != 0);
         s0_tag_match    = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
         s0_way_vld      = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
         s0_tag_perr     = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0;
         s0_tlb_cam_miss = ($urandom_range(0, 7) == 0);
         stall           = ($urandom_range(0, 3) == 0);
         flush           = ($urandom_range(0, 7) == 0);
         fill_ack        = ($urandom_range(0, 3) == 0);
         step();
         e = exp_vec();
         checks++;
         if (dut_vec !== e) begin
            failures++; $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec, e);
         end
      end
      reset = 0;
      idle_inputs();
   endtask

   initial begin
      m_way = 0; m_err = 0; m_tlb = 0; m_cam = 0; m_state = M_IDLE; m_cnt = 0;
      test_reset();
      test_hit();
      test_mhit_stall();
      test_miss();
      test_err();
      test_flush_req();
      test_reset_wait();
      test_saturation();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
